// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the sequential InvMixColumns block.
package inv_mix_columns_seq_pkg;

    localparam int STATE_W = 128;
    localparam int COL_W   = 32;
    localparam int NCOLS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } imc_state_e;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Upstream/downstream handshake bundle for inv_mix_columns_seq.
interface inv_mix_columns_seq_if;
    import inv_mix_columns_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               in_bypass;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;

    modport master (
        output in_valid, in_state, in_bypass, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_bypass, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/inv_mix_columns_seq_helper.sv
// Combinational inverse MixColumns on one 32-bit column, byte 0 in the MSB.
module MixColumnHelper
    import inv_mix_columns_seq_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [3:0][7:0] a, m9, mb, md, me, r;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_byte
            logic [7:0] x2, x4, x8;
            assign a[i]  = col_in[31-8*i -: 8];
            assign x2    = xtime(a[i]);
            assign x4    = xtime(x2);
            assign x8    = xtime(x4);
            assign m9[i] = x8 ^ a[i];
            assign mb[i] = x8 ^ x2 ^ a[i];
            assign md[i] = x8 ^ x4 ^ a[i];
            assign me[i] = x8 ^ x4 ^ x2;
            // Row i is the base row {0e,0b,0d,09} rotated right by i.
            assign r[i]  = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
            assign col_out[31-8*i -: 8] = r[i];
        end
    endgenerate

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial InvMixColumns: one shared helper, four RUN cycles per state, optional bypass.
module inv_mix_columns_seq #(
    parameter int COL_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_mix_columns_seq_if.slave  bus,
    output logic                  busy
);
    import inv_mix_columns_seq_pkg::*;

    imc_state_e         state;
    logic [1:0]         col;
    logic               byp;
    logic [STATE_W-1:0] work;
    logic               out_valid_q;
    logic               busy_q;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;

    always_comb begin
        col_in = '0;
        case (col)
            2'd0: col_in = work[STATE_W-1         -: COL_W];
            2'd1: col_in = work[STATE_W-1-COL_W   -: COL_W];
            2'd2: col_in = work[STATE_W-1-2*COL_W -: COL_W];
            2'd3: col_in = work[STATE_W-1-3*COL_W -: COL_W];
            default: col_in = '0;
        endcase
    end

    MixColumnHelper u_helper (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            col         <= '0;
            byp         <= 1'b0;
            work        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work   <= bus.in_state;
                        byp    <= bus.in_bypass;
                        col    <= '0;
                        busy_q <= 1'b1;
                        if (bus.in_bypass) begin
                            state       <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // A bypassed state never reaches RUN; the guard keeps it off the helper path regardless.
                    if (!byp) begin
                        case (col)
                            2'd0: work[STATE_W-1         -: COL_W] <= col_out;
                            2'd1: work[STATE_W-1-COL_W   -: COL_W] <= col_out;
                            2'd2: work[STATE_W-1-2*COL_W -: COL_W] <= col_out;
                            2'd3: work[STATE_W-1-3*COL_W -: COL_W] <= col_out;
                            default: ;
                        endcase
                    end
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        state       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst so the block never advertises readiness while held in reset.
    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = work;
    assign busy          = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboarded random/directed bench for inv_mix_columns_seq against a GF(2^8) matrix model.
module tb_inv_mix_columns_seq;

    logic clk;
    logic rst;
    logic busy;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [127:0] st;
        logic         byp;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    logic seen;
    logic tput_on;
    logic rand_rdy;
    int   prev_hs;

    inv_mix_columns_seq_if bus();

    inv_mix_columns_seq #(.COL_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: carry-less product then reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   o;
        logic [127:0] res;
        if (byp) return s;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) o = o ^ gmul(coef[(k - r + 4) % 4], a[k]);
                res[127 - 32*c - 8*r -: 8] = o;
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive after posedge, sample in_ready at negedge; the transfer edge closes the sampled cycle.
    task automatic send(input logic [127:0] s, input logic b, input logic [127:0] expv);
        int n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_state  = s;
        bus.in_bypass = b;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("send_timeout", 128'(n), 128'(0));
        end else begin
            e.st = expv; e.byp = b; e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_state  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_bypass = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            chk("busy_in_done", 128'(busy), 128'(1));
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 128'(1), 128'(0));
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 128'(cyc - exp_q[0].cyc), exp_q[0].byp ? 128'(1) : 128'(5));
                end
                if (bus.out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_state", bus.out_state, e.st);
                    seen = 1'b0;
                    if (tput_on && prev_hs >= 0) chk("throughput", 128'(cyc - prev_hs), 128'(6));
                    prev_hs = cyc;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s, cap;
        logic         b;
        int           n;
        cyc = 0; checks = 0; errors = 0;
        seen = 1'b0; tput_on = 1'b0; rand_rdy = 1'b0; prev_hs = -1;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_state = '0; bus.in_bypass = 1'b0; bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_state", bus.out_state, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 128'(bus.in_ready), 128'(1));

        // Scenario 1-3: directed vectors
        send({4{32'h9fdc589d}}, 1'b0, {4{32'hf20a225c}});
        drain();
        send({32'h8e4da1bc, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'h01010101}, 1'b0,
             {32'hdb135345, 32'hd4d4d4d5, 32'h2d26314c, 32'h01010101});
        drain();
        send(128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff);
        drain();

        // Scenario 4: backpressure in DONE
        bus.out_ready = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0, model(s, 1'b0));
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_rise", 128'(bus.out_valid), 128'(1));
        cap = bus.out_state;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_out_state", bus.out_state, cap);
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("hs_in_ready_low", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        chk("post_hs_in_ready", 128'(bus.in_ready), 128'(1));
        chk("post_hs_out_valid", 128'(bus.out_valid), 128'(0));

        // Scenario 5: reset mid-RUN (col 2) abandons the operation
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0, model(s, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        send({4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}});
        drain();

        // Scenario 6: back-to-back random states at full rate
        tput_on = 1'b1;
        prev_hs = -1;
        for (int i = 0; i < 20; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            send(s, 1'b0, model(s, 1'b0));
        end
        drain();
        tput_on = 1'b0;

        // Mixed bypass with random downstream stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            b = 1'($urandom_range(0, 1));
            send(s, b, model(s, b));
        end
        drain();
        rand_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
